// File: rtl/rca_pkg.sv
// Shared constants and types for the ripple-carry accumulator slice.
// Holds the FSM encoding, datapath width and default settle window.
package rca_pkg;

  localparam int RCA_WIDTH        = 4;
  localparam int TIMER_W          = 4;
  localparam int SETTLE_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // A subtract is done as a + ~b + 1, so a missing carry-out is the borrow.
  function automatic logic wrap_event(input logic is_sub, input logic cout);
    return is_sub ? ~cout : cout;
  endfunction

endpackage

// File: rtl/rca_accumulator_if.sv
// Operand/result handshake plus the external adder hookup for rca_accumulator.
// slave = the accumulator, master = whatever feeds it, consumes results and models the adder.
interface rca_accumulator_if #(
  parameter int OVF_W = 8
);
  import rca_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [RCA_WIDTH-1:0] in_data;
  logic                 in_sub;
  logic [RCA_WIDTH-1:0] add_a;
  logic [RCA_WIDTH-1:0] add_b;
  logic                 add_cin;
  logic [RCA_WIDTH-1:0] add_s;
  logic                 add_cout;
  logic                 out_valid;
  logic                 out_ready;
  logic [RCA_WIDTH-1:0] acc;
  logic                 out_carry;
  logic [OVF_W-1:0]     ovf_count;

  modport slave (
    input  in_valid, in_data, in_sub, add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, acc, out_carry, ovf_count
  );

  modport master (
    output in_valid, in_data, in_sub, add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, acc, out_carry, ovf_count
  );

endinterface

// File: rtl/rca_accumulator_settle_timer.sv
// settle_timer: loadable down-counter with zero flag; load takes effect next edge.
// No backpressure; decrement stops at zero, clr has priority over load.
module settle_timer
  import rca_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TIMER_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rca_accumulator.sv
// Accumulator around an external 4-bit ripple adder: launch, wait SETTLE_CYCLES, capture.
// Result is held in HOLD until out_ready; in_ready only in IDLE, so one op per SETTLE_CYCLES+1 at best.
module rca_accumulator
  import rca_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int OVF_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  rca_accumulator_if.slave   bus
);

  state_t state_q, state_d;

  logic [RCA_WIDTH-1:0] add_a_q, add_b_q, acc_q;
  logic                 add_cin_q, out_carry_q, op_sub_q;
  logic [OVF_W-1:0]     ovf_q;
  logic                 accept, capture, timer_zero;
  logic                 in_ready_c, out_valid_c;

  // clear shares the reset path for every register, so it overrides any handshake.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timer_zero) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  settle_timer u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (clear),
    .load     (accept),
    .load_val (TIMER_W'(SETTLE_CYCLES - 1)),
    .dec      (state_q == ST_SETTLE),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      op_sub_q    <= 1'b0;
      acc_q       <= '0;
      out_carry_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      if (accept) begin
        add_a_q   <= acc_q;
        add_b_q   <= bus.in_sub ? ~bus.in_data : bus.in_data;
        add_cin_q <= bus.in_sub;
        op_sub_q  <= bus.in_sub;
      end
      if (capture) begin
        acc_q       <= bus.add_s;
        out_carry_q <= bus.add_cout;
        if (wrap_event(op_sub_q, bus.add_cout) && (ovf_q != '1)) begin
          ovf_q <= ovf_q + OVF_W'(1);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.acc       = acc_q;
  assign bus.out_carry = out_carry_q;
  assign bus.ovf_count = ovf_q;

endmodule

// File: doc/rca_accumulator.md
# rca_accumulator

Sequential accumulator wrapped around the team's 4-bit combinational ripple-carry adder. It drives the adder's operand and carry-in inputs from registered state, waits a programmable settle window for the ripple to resolve, then captures sum and carry-out. Captured results are presented on a valid/ready output. The adder sits between this block's `add_*` outputs and `add_s`/`add_cout` inputs, so the block is both the adder's upstream feeder and its downstream consumer; outputs are suitable for ILA probing.

## Interface
- `SETTLE_CYCLES`, 2, clock cycles between operand launch and result capture; legal range 1..15.
- `OVF_W`, 8, width of the saturating carry/borrow event counter.
- `clk`  in  1  rising-edge clock; one clock domain.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `clear`  in  1  synchronous clear of accumulator and counter.
- `in_valid`  in  1  operand offered.
- `in_ready`  out  1  block can accept an operand.
- `in_data`  in  4  operand.
- `in_sub`  in  1  1 = subtract operand, 0 = add.
- `add_a`  out  4  adder operand A (registered).
- `add_b`  out  4  adder operand B (registered).
- `add_cin`  out  1  adder carry-in (registered).
- `add_s`  in  4  adder sum.
- `add_cout`  in  1  adder carry-out.
- `out_valid`  out  1  captured result available.
- `out_ready`  in  1  consumer takes the result.
- `acc`  out  4  accumulator value.
- `out_carry`  out  1  carry-out of the last operation.
- `ovf_count`  out  OVF_W  saturating count of wrap events.

## Operation
- The FSM has three states: IDLE, SETTLE and HOLD. `reset` forces IDLE.
- **Reset values:** `acc`=0, `out_carry`=0, `ovf_count`=0, `add_a`=0, `add_b`=0, `add_cin`=0, `out_valid`=0, `in_ready`=1, settle counter=0.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid` the block accepts the operand: `add_a`<=`acc`; `add_b`<=`in_sub` ? ~`in_data` : `in_data`; `add_cin`<=`in_sub`. The op type is latched, the settle counter loads `SETTLE_CYCLES`-1, and the FSM goes to SETTLE.
- **SETTLE:**
  - `in_ready`=0; `add_*` held constant.
  - The counter decrements each cycle.
  - On the cycle the counter is 0: `acc`<=`add_s`, `out_carry`<=`add_cout`, then go to HOLD.
  - A wrap event is `add_cout`=1 for an add, or `add_cout`=0 (borrow) for a subtract. On a wrap event, `ovf_count` increments, saturating at 2^OVF_W-1.
- **HOLD:**
  - `out_valid`=1 and `in_ready`=0.
  - On `out_ready`, go to IDLE.
  - `acc`, `out_carry` and `add_*` are stable for the whole of HOLD.
- **Arithmetic:** everything is modulo 16; the block does no internal addition and uses the adder result only. The counter is OVF_W-bit unsigned; no other arithmetic.
- **`clear`:**
  - Priority: `reset` > `clear` > everything else.
  - In any state, `clear` sets `acc`=0, `out_carry`=0, `ovf_count`=0 and `add_*`=0, drops `out_valid`, and returns the FSM to IDLE.
  - An operation in flight is discarded.
  - An operand offered in the same cycle as `clear` is not accepted, even though `in_ready`=1 in IDLE.
- **Reset mid-operation:** same effect as `clear`, plus all outputs take their reset values on the next edge.

## Timing
- Operand accepted at edge E0; `add_*` valid after E0.
- Capture occurs at edge E0+`SETTLE_CYCLES`; `out_valid` is high from that edge.
- If `out_ready` is held high, `in_ready` returns at edge E0+`SETTLE_CYCLES`+1.
- Peak throughput is one operation per `SETTLE_CYCLES`+1 cycles.
- `in_ready` is a pure function of state; there is no combinational path from `in_valid` to `in_ready`.
- `out_valid` is registered and does not depend combinationally on `out_ready`.
- `SETTLE_CYCLES` must cover the adder's ripple delay plus routing at the target clock.

## Structure
- Shared package `rca_pkg`:
  - FSM state encoding constants.
  - `RCA_WIDTH`=4.
  - Default `SETTLE_CYCLES`.
- One natural sub-module, `settle_timer`: a loadable down-counter with a zero flag.
- The adder is instantiated beside this block in the lab top-level, not inside it.

## Test plan
- **Basic add:** after reset, drive `in_data`=3 add. Expect `add_a`=0, `add_b`=3, `add_cin`=0. After 2 cycles expect `acc`=3, `out_carry`=0 and `out_valid`=1; `ovf_count` stays 0.
- **Wrap:** with `acc`=12, add 5. Expect `acc`=1, `out_carry`=1 and `ovf_count`=1.
- **Subtract:** with `acc`=7, subtract 2. Expect `add_b`=4'b1101, `add_cin`=1, `acc`=5 and `out_carry`=1, with no count increment. Then subtract 9: expect `acc`=12, `out_carry`=0 and `ovf_count`+1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in HOLD. Expect `out_valid`, `acc` and `add_*` stable and `in_ready`=0 throughout. Offered operands are not accepted until one cycle after `out_ready`=1.
- **Clear mid-SETTLE:** with `acc`=9, accept add 4, then assert `clear` on the cycle after acceptance. Expect `acc`=0, state IDLE, `out_valid` never asserted, and `ovf_count`=0.
- **Saturation:** with `OVF_W`=2, perform 5 wrapping adds. Expect `ovf_count`=3 after the 3rd add, and still 3 after the 5th.
